// File: rtl/src_ctrl_pkg.sv
// Shared control definitions for the Mini-SRC sequencer: FSM states,
// ALU opcode encodings and IR field positions.
package src_ctrl_pkg;

   typedef enum logic [3:0] {
      ST_IDLE = 4'd0,
      ST_T0   = 4'd1,
      ST_T1   = 4'd2,
      ST_T2   = 4'd3,
      ST_DEC  = 4'd4,
      ST_T3   = 4'd5,
      ST_T4   = 4'd6,
      ST_T5   = 4'd7,
      ST_ILL  = 4'd8
   } state_t;

   // Values must track the ALU's own opcode decode.
   localparam logic [4:0] OP_ADD  = 5'd3;
   localparam logic [4:0] OP_SUB  = 5'd4;
   localparam logic [4:0] OP_SHR  = 5'd5;
   localparam logic [4:0] OP_SHRA = 5'd6;
   localparam logic [4:0] OP_SHL  = 5'd7;
   localparam logic [4:0] OP_ROR  = 5'd8;
   localparam logic [4:0] OP_ROL  = 5'd9;
   localparam logic [4:0] OP_AND  = 5'd10;
   localparam logic [4:0] OP_OR   = 5'd11;

   localparam int OPC_MSB = 31;
   localparam int OPC_LSB = 27;
   localparam int RA_MSB  = 26;
   localparam int RA_LSB  = 23;
   localparam int RB_MSB  = 22;
   localparam int RB_LSB  = 19;
   localparam int RC_MSB  = 18;
   localparam int RC_LSB  = 15;

   typedef struct packed {
      logic [4:0] opcode;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] rc;
   } ir_fields_t;

   function automatic logic is_r_format(input logic [4:0] op);
      logic ok;
      case (op)
         OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
         OP_ROR, OP_ROL, OP_AND, OP_OR: ok = 1'b1;
         default:                       ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational split of an R-format instruction word into opcode and
// register fields, with a flag saying whether the opcode is supported.
module ir_field_decode
   import src_ctrl_pkg::*;
(
   input  logic [31:0] i_ir,
   output ir_fields_t  o_fields,
   output logic        o_r_format_valid
);

   // The low bits carry no meaning for R-format instructions.
   logic w_unused_low;
   assign w_unused_low = ^i_ir[RC_LSB-1:0];

   assign o_fields.opcode   = i_ir[OPC_MSB:OPC_LSB];
   assign o_fields.ra       = i_ir[RA_MSB:RA_LSB];
   assign o_fields.rb       = i_ir[RB_MSB:RB_LSB];
   assign o_fields.rc       = i_ir[RC_MSB:RC_LSB];
   assign o_r_format_valid  = is_r_format(i_ir[OPC_MSB:OPC_LSB]);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/execute control FSM for R-format instructions on the Mini-SRC
// datapath; owns the ALU opcode, the register strobes and the retire count.
module alu_sequencer
   import src_ctrl_pkg::*;
#(
   parameter int INSTR_W = 32,
   parameter int CNT_W   = 16
)(
   input  logic               clock,
   input  logic               clear,
   input  logic               run,
   input  logic               mem_ready,
   input  logic [INSTR_W-1:0] ir,
   output logic               pc_out,
   output logic               mar_in,
   output logic               inc_pc,
   output logic               z_in,
   output logic               zlo_out,
   output logic               pc_in,
   output logic               mem_read,
   output logic               mdr_in,
   output logic               mdr_out,
   output logic               ir_in,
   output logic               y_in,
   output logic               rf_out,
   output logic               rf_in,
   output logic [3:0]         rf_sel,
   output logic [4:0]         alu_op,
   output logic               busy,
   output logic               illegal,
   output logic [CNT_W-1:0]   retired
);

   state_t           r_state;
   state_t           w_next_state;
   logic             r_pc_done;
   ir_fields_t       r_fields;
   ir_fields_t       w_fields;
   logic             w_valid;
   logic [CNT_W-1:0] r_retired;

   ir_field_decode u_decode (
      .i_ir             (ir[31:0]),
      .o_fields         (w_fields),
      .o_r_format_valid (w_valid)
   );

   always_ff @(posedge clock) begin
      if (clear) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: w_next_state = run ? ST_T0 : ST_IDLE;
         ST_T0:   w_next_state = ST_T1;
         ST_T1:   w_next_state = mem_ready ? ST_T2 : ST_T1;
         ST_T2:   w_next_state = ST_DEC;
         ST_DEC:  w_next_state = w_valid ? ST_T3 : ST_ILL;
         ST_T3:   w_next_state = ST_T4;
         ST_T4:   w_next_state = ST_T5;
         ST_T5:   w_next_state = run ? ST_T0 : ST_IDLE;
         ST_ILL:  w_next_state = run ? ST_T0 : ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_out   = 1'b0;
      mar_in   = 1'b0;
      inc_pc   = 1'b0;
      z_in     = 1'b0;
      zlo_out  = 1'b0;
      pc_in    = 1'b0;
      mem_read = 1'b0;
      mdr_in   = 1'b0;
      mdr_out  = 1'b0;
      ir_in    = 1'b0;
      y_in     = 1'b0;
      rf_out   = 1'b0;
      rf_in    = 1'b0;
      rf_sel   = 4'd0;
      alu_op   = 5'd0;
      illegal  = 1'b0;
      case (r_state)
         ST_T0: begin
            pc_out = 1'b1;
            mar_in = 1'b1;
            inc_pc = 1'b1;
            z_in   = 1'b1;
         end
         ST_T1: begin
            zlo_out  = 1'b1;
            pc_in    = ~r_pc_done;
            mem_read = 1'b1;
            mdr_in   = 1'b1;
         end
         ST_T2: begin
            mdr_out = 1'b1;
            ir_in   = 1'b1;
         end
         ST_T3: begin
            rf_out = 1'b1;
            rf_sel = r_fields.rb;
            y_in   = 1'b1;
         end
         ST_T4: begin
            rf_out = 1'b1;
            rf_sel = r_fields.rc;
            alu_op = r_fields.opcode;
            z_in   = 1'b1;
         end
         ST_T5: begin
            zlo_out = 1'b1;
            rf_in   = 1'b1;
            rf_sel  = r_fields.ra;
         end
         ST_ILL:  illegal = 1'b1;
         default: ;
      endcase
   end

   assign busy    = (r_state != ST_IDLE);
   assign retired = r_retired;

   // Remembers that PC was already loaded in this T1 stall so it advances once.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_pc_done <= 1'b0;
      end else begin
         r_pc_done <= (r_state == ST_T1);
      end
   end

   // Fields are captured once per instruction so later IR changes are ignored.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_fields <= '0;
      end else if (r_state == ST_DEC && w_valid) begin
         r_fields <= w_fields;
      end else begin
         r_fields <= r_fields;
      end
   end

   // Retire count advances on the write-back cycle and wraps naturally.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_retired <= '0;
      end else if (r_state == ST_T5) begin
         r_retired <= r_retired + CNT_W'(1);
      end else begin
         r_retired <= r_retired;
      end
   end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: expected per-cycle outputs are queued
// when an instruction is launched and compared on every falling edge.
module tb_alu_sequencer;

   localparam int CW = 8;

   localparam int S_IDLE = 0;
   localparam int S_T0   = 1;
   localparam int S_T1F  = 2;
   localparam int S_T1S  = 3;
   localparam int S_T2   = 4;
   localparam int S_DEC  = 5;
   localparam int S_T3   = 6;
   localparam int S_T4   = 7;
   localparam int S_T5   = 8;
   localparam int S_ILL  = 9;

   logic          clock = 1'b0;
   logic          clear;
   logic          run;
   logic          mem_ready;
   logic [31:0]   ir;
   logic          pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read;
   logic          mdr_in, mdr_out, ir_in, y_in, rf_out, rf_in, busy, illegal;
   logic [3:0]    rf_sel;
   logic [4:0]    alu_op;
   logic [CW-1:0] retired;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [CW-1:0] exp_ret = '0;
   logic [23:0]   q_vec[$];
   logic [CW-1:0] q_ret[$];
   int            q_st[$];
   logic [23:0]   w_obs;

   alu_sequencer #(.INSTR_W(32), .CNT_W(CW)) dut (
      .clock(clock), .clear(clear), .run(run), .mem_ready(mem_ready), .ir(ir),
      .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .z_in(z_in),
      .zlo_out(zlo_out), .pc_in(pc_in), .mem_read(mem_read), .mdr_in(mdr_in),
      .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .rf_out(rf_out),
      .rf_in(rf_in), .rf_sel(rf_sel), .alu_op(alu_op), .busy(busy),
      .illegal(illegal), .retired(retired)
   );

   always #5 clock = ~clock;

   assign w_obs = {pc_out, mar_in, inc_pc, z_in, zlo_out, pc_in, mem_read, mdr_in,
                   mdr_out, ir_in, y_in, rf_out, rf_in, rf_sel, alu_op, busy, illegal};

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [23:0] exp_vec(input int st, input logic [4:0] op,
                                           input logic [3:0] ra, input logic [3:0] rb,
                                           input logic [3:0] rc);
      logic [23:0] v;
      v = 24'h0;
      case (st)
         S_T0:  begin v[23] = 1'b1; v[22] = 1'b1; v[21] = 1'b1; v[20] = 1'b1; end
         S_T1F: begin v[19] = 1'b1; v[18] = 1'b1; v[17] = 1'b1; v[16] = 1'b1; end
         S_T1S: begin v[19] = 1'b1; v[17] = 1'b1; v[16] = 1'b1; end
         S_T2:  begin v[15] = 1'b1; v[14] = 1'b1; end
         S_T3:  begin v[12] = 1'b1; v[13] = 1'b1; v[10:7] = rb; end
         S_T4:  begin v[12] = 1'b1; v[20] = 1'b1; v[10:7] = rc; v[6:2] = op; end
         S_T5:  begin v[19] = 1'b1; v[11] = 1'b1; v[10:7] = ra; end
         S_ILL: v[0] = 1'b1;
         default: ;
      endcase
      if (st != S_IDLE) v[1] = 1'b1;
      return v;
   endfunction

   task automatic push(input int st, input logic [31:0] irv);
      q_vec.push_back(exp_vec(st, irv[31:27], irv[26:23], irv[22:19], irv[18:15]));
      q_ret.push_back(exp_ret);
      q_st.push_back(st);
   endtask

   task automatic step();
      int st;
      @(negedge clock);
      if (q_vec.size() == 0) begin
         chk("sb_underflow", 32'd1, 32'd0);
      end else begin
         st = q_st.pop_front();
         chk($sformatf("outputs_st%0d", st), {8'h0, w_obs}, {8'h0, q_vec.pop_front()});
         chk($sformatf("retired_st%0d", st), {24'h0, retired}, {24'h0, q_ret.pop_front()});
      end
   endtask

   // Runs one instruction from IDLE back to IDLE with the given T1 stall count.
   task automatic do_instr(input logic [31:0] irv, input int stalls);
      logic [4:0] op;
      logic       ok;
      op = irv[31:27];
      ok = (op >= 5'd3) && (op <= 5'd11);
      push(S_T0, irv);
      push(S_T1F, irv);
      for (int k = 0; k < stalls; k++) push(S_T1S, irv);
      push(S_T2, irv);
      push(S_DEC, irv);
      if (ok) begin
         push(S_T3, irv); push(S_T4, irv); push(S_T5, irv);
         exp_ret = exp_ret + 1'b1;
      end else begin
         push(S_ILL, irv);
      end
      push(S_IDLE, irv);
      ir = irv; run = 1'b1; mem_ready = 1'b0;
      step();
      run = 1'b0;
      for (int j = 1; j <= stalls + 1; j++) begin
         step();
         mem_ready = (j > stalls);
      end
      step(); step();
      if (ok) begin
         step(); step(); step();
      end else begin
         step();
      end
      step();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: run did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] irv;
      clear = 1'b1; run = 1'b0; mem_ready = 1'b1; ir = 32'h0;
      @(negedge clock);
      push(S_IDLE, 32'h0); step();
      clear = 1'b0;
      push(S_IDLE, 32'h0); step();

      // Add r1,r2,r3 without and with T1 stalls, then an unsupported opcode.
      do_instr(32'h18918000, 0);
      do_instr(32'h18918000, 3);
      do_instr(32'h60000000, 0);

      // Sub with run dropped and IR disturbed during T3.
      irv = 32'h20000000;
      push(S_T0, irv); push(S_T1F, irv); push(S_T2, irv); push(S_DEC, irv);
      push(S_T3, irv); push(S_T4, irv); push(S_T5, irv);
      exp_ret = exp_ret + 1'b1;
      push(S_IDLE, irv);
      ir = irv; run = 1'b1; mem_ready = 1'b1;
      repeat (5) step();
      run = 1'b0; ir = 32'h18918000;
      repeat (3) step();

      // Every opcode with random register fields and varying stalls.
      for (int op = 0; op < 32; op++) begin
         irv = {op[4:0], 27'($urandom)};
         do_instr(irv, op % 3);
      end

      // Clear in T4 aborts before write-back and zeroes the count.
      irv = 32'h18918000;
      push(S_T0, irv); push(S_T1F, irv); push(S_T2, irv); push(S_DEC, irv);
      push(S_T3, irv); push(S_T4, irv);
      exp_ret = '0;
      push(S_IDLE, irv); push(S_IDLE, irv);
      ir = irv; run = 1'b1; mem_ready = 1'b1;
      step();
      run = 1'b0;
      repeat (5) step();
      clear = 1'b1;
      step();
      clear = 1'b0;
      step();

      // Back-to-back Or instructions until the count wraps.
      irv = 32'h58000000;
      ir = irv; run = 1'b1; mem_ready = 1'b1;
      for (int k = 0; k < (1 << CW); k++) begin
         push(S_T0, irv); push(S_T1F, irv); push(S_T2, irv); push(S_DEC, irv);
         push(S_T3, irv); push(S_T4, irv); push(S_T5, irv);
         exp_ret = exp_ret + 1'b1;
         step();
         if (k == (1 << CW) - 1) run = 1'b0;
         repeat (6) step();
      end
      push(S_IDLE, irv);
      step();
      chk("wrap_retired", {24'h0, retired}, 32'h0);
      chk("sb_empty", q_vec.size(), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
